// File: rtl/dco_tune_encoder.sv
// Binary DCO tuning word to thermometer unit enables, with first-order
// sigma-delta dither of the fraction and slew-limited unit count.
module dco_tune_encoder #(
    parameter int INT_W    = 4,
    parameter int FRAC_W   = 4,
    parameter int MAX_STEP = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INT_W+FRAC_W-1:0]  tune_word,
    input  logic                     tune_valid,
    input  logic                     dither_en,
    output logic [(1<<INT_W)-2:0]    therm_en,
    output logic [INT_W-1:0]         unit_count,
    output logic                     busy
);

    localparam int N_UNITS = (1 << INT_W) - 1;
    localparam logic [INT_W:0] N_UNITS_W  = (INT_W+1)'(N_UNITS);
    localparam logic [INT_W:0] MAX_STEP_W = (INT_W+1)'(MAX_STEP);

    logic [INT_W-1:0]   target_int_reg;
    logic [FRAC_W-1:0]  target_frac_reg;
    logic [FRAC_W-1:0]  acc_reg;
    logic [INT_W-1:0]   count_reg;
    logic [N_UNITS-1:0] therm_reg;

    logic [FRAC_W-1:0]  acc_next;
    logic               carry;
    logic [INT_W:0]     goal_wide;
    logic [INT_W:0]     goal;
    logic [INT_W:0]     count_wide;
    logic [INT_W:0]     diff_up;
    logic [INT_W:0]     diff_down;
    logic [INT_W:0]     target_plus1;
    logic [INT_W-1:0]   count_next;
    logic [N_UNITS-1:0] therm_next;

    // Dither, saturated goal and slew limit; all arithmetic at INT_W+1 bits.
    always_comb begin
        acc_next = '0;
        carry    = 1'b0;
        if (dither_en) begin
            {carry, acc_next} = {1'b0, acc_reg} + {1'b0, target_frac_reg};
        end

        goal_wide  = {1'b0, target_int_reg} + {{INT_W{1'b0}}, carry};
        goal       = (goal_wide > N_UNITS_W) ? N_UNITS_W : goal_wide;
        count_wide = {1'b0, count_reg};
        diff_up    = goal - count_wide;
        diff_down  = count_wide - goal;

        count_next = count_reg;
        if (goal > count_wide) begin
            count_next = count_reg + INT_W'((diff_up < MAX_STEP_W) ? diff_up : MAX_STEP_W);
        end else if (goal < count_wide) begin
            count_next = count_reg - INT_W'((diff_down < MAX_STEP_W) ? diff_down : MAX_STEP_W);
        end
    end

    // Decode the next count so the enables come straight from flops.
    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_therm
            localparam logic [INT_W-1:0] IDX = INT_W'(gi);
            assign therm_next[gi] = (IDX < count_next);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_int_reg  <= '0;
            target_frac_reg <= '0;
            acc_reg         <= '0;
            count_reg       <= '0;
            therm_reg       <= '0;
        end else begin
            if (tune_valid) begin
                target_int_reg  <= tune_word[INT_W+FRAC_W-1:FRAC_W];
                target_frac_reg <= tune_word[FRAC_W-1:0];
            end
            acc_reg   <= acc_next;
            count_reg <= count_next;
            therm_reg <= therm_next;
        end
    end

    // Sitting one unit above target is the normal dither toggle, not a ramp.
    assign target_plus1 = {1'b0, target_int_reg} + {{INT_W{1'b0}}, 1'b1};
    assign busy = !((count_reg == target_int_reg) ||
                    (dither_en && (count_wide == target_plus1)));

    assign therm_en   = therm_reg;
    assign unit_count = count_reg;

endmodule
